// File: rtl/speles_kontrolieris.sv
// Guessing-game controller: LFSR target, external equality comparator, score/round bookkeeping.
// Latency: guess_valid at cycle N -> hit/miss at N+2; no backpressure, ignored pulses are simply dropped.
// Optional per-guess timeout is compiled in with SPELE_TIMEOUT_EN.
module speles_kontrolieris #(
    parameter int ROUNDS      = 8,
    parameter int ROUND_TICKS = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [0:3] guess,
    input  logic       guess_valid,
    output logic [0:3] cmp_num_1,
    output logic [0:3] cmp_num_2,
    input  logic       cmp_match,
    output logic [0:3] score,
    output logic [0:3] round_no,
    output logic       hit,
    output logic       miss,
    output logic       busy,
    output logic       game_over
);

    if (ROUNDS < 1 || ROUNDS > 15 || ROUND_TICKS < 2 || ROUND_TICKS > 255) begin : g_bad_param
        $error("speles_kontrolieris: ROUNDS or ROUND_TICKS out of range");
    end

    typedef enum logic [2:0] {
        IDLE,
        NEW_ROUND,
        WAIT_GUESS,
        COMPARE,
        RESULT,
        DONE
    } state_t;

    localparam logic [0:3] ROUNDS_L  = 4'(ROUNDS);
    localparam logic [0:3] LFSR_SEED = 4'b1001;

    state_t     state_q, state_d;
    logic [0:3] lfsr_q, lfsr_d;
    logic [0:3] target_q, target_d;
    logic [0:3] guess_q, guess_d;
    logic       flag_q, flag_d;
    logic [0:3] score_q, score_d;
    logic [0:3] round_q, round_d;
`ifdef SPELE_TIMEOUT_EN
    localparam logic [7:0] TICK_LAST = 8'(ROUND_TICKS - 1);
    logic [7:0] tick_q, tick_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            lfsr_q   <= LFSR_SEED;
            target_q <= '0;
            guess_q  <= '0;
            flag_q   <= 1'b0;
            score_q  <= '0;
            round_q  <= '0;
`ifdef SPELE_TIMEOUT_EN
            tick_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            target_q <= target_d;
            guess_q  <= guess_d;
            flag_q   <= flag_d;
            score_q  <= score_d;
            round_q  <= round_d;
`ifdef SPELE_TIMEOUT_EN
            tick_q   <= tick_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        // Fibonacci form of x^4+x^3+1; index 0 is the MSB on these [0:3] vectors.
        lfsr_d   = {lfsr_q[1:3], lfsr_q[0] ^ lfsr_q[1]};
        target_d = target_q;
        guess_d  = guess_q;
        flag_d   = flag_q;
        score_d  = score_q;
        round_d  = round_q;
`ifdef SPELE_TIMEOUT_EN
        tick_d   = tick_q;
`endif
        hit      = 1'b0;
        miss     = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    score_d = '0;
                    round_d = '0;
                    state_d = NEW_ROUND;
                end
            end
            NEW_ROUND: begin
                target_d = lfsr_q;
`ifdef SPELE_TIMEOUT_EN
                tick_d   = '0;
`endif
                state_d  = WAIT_GUESS;
            end
            WAIT_GUESS: begin
                // A guess arriving in the expiry cycle still wins over the timeout.
                if (guess_valid) begin
                    guess_d = guess;
                    state_d = COMPARE;
                end
`ifdef SPELE_TIMEOUT_EN
                else if (tick_q == TICK_LAST) begin
                    flag_d  = 1'b0;
                    state_d = RESULT;
                end else begin
                    tick_d = tick_q + 8'd1;
                end
`endif
            end
            COMPARE: begin
                flag_d  = cmp_match;
                state_d = RESULT;
            end
            RESULT: begin
                hit     = flag_q;
                miss    = !flag_q;
                if (flag_q) begin
                    score_d = score_q + 4'd1;
                end
                round_d = round_q + 4'd1;
                state_d = (round_d == ROUNDS_L) ? DONE : NEW_ROUND;
            end
            default: state_d = IDLE;
        endcase
    end

    assign cmp_num_1 = target_q;
    assign cmp_num_2 = guess_q;
    assign score     = score_q;
    assign round_no  = round_q;
    assign busy      = (state_q != IDLE) && (state_q != DONE);
    assign game_over = (state_q == DONE);

endmodule

// File: doc/speles_kontrolieris.md
SPELES_KONTROLIERIS -- requirements
Module: speles_kontrolieris

Interface
REQ-001 Parameter ROUNDS, default 8, sets the number of rounds per game (legal range 1..15).
REQ-002 Parameter ROUND_TICKS, default 16, sets the clock cycles allowed per guess when the timeout is compiled in (legal range 2..255).
REQ-003 Port clk, input, 1 bit: single clock; all logic on the rising edge.
REQ-004 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 Port start, input, 1 bit: one-cycle pulse that begins a game.
REQ-006 Port guess, input, 4 bits [0:3]: player number from the switches.
REQ-007 Port guess_valid, input, 1 bit: one-cycle pulse that submits guess.
REQ-008 Port cmp_num_1, output, 4 bits [0:3]: target number, drives comparator num_1.
REQ-009 Port cmp_num_2, output, 4 bits [0:3]: latched guess, drives comparator num_2.
REQ-010 Port cmp_match, input, 1 bit: combinational equality result from the comparator.
REQ-011 Port score, output, 4 bits [0:3]: number of hits in the current game.
REQ-012 Port round_no, output, 4 bits [0:3]: number of completed rounds.
REQ-013 Port hit, output, 1 bit: one-cycle pulse, correct guess.
REQ-014 Port miss, output, 1 bit: one-cycle pulse, wrong guess or timeout.
REQ-015 Port busy, output, 1 bit: high in every state except IDLE and DONE.
REQ-016 Port game_over, output, 1 bit: high while in DONE.

Function
REQ-017 FSM states SHALL be IDLE, NEW_ROUND, WAIT_GUESS, COMPARE, RESULT and DONE, each one cycle long except WAIT_GUESS, IDLE and DONE.
REQ-018 IDLE or DONE with start=1 SHALL clear score and round_no and go to NEW_ROUND; start in any other state SHALL be ignored.
REQ-019 A 4-bit maximal-length LFSR (x^4+x^3+1, never zero) SHALL advance every cycle.
REQ-020 NEW_ROUND SHALL load the LFSR value into the target register, clear the tick timer and go to WAIT_GUESS.
REQ-021 WAIT_GUESS with guess_valid=1 SHALL latch guess into the guess register and go to COMPARE.
REQ-022 guess_valid outside WAIT_GUESS SHALL be ignored, with no change to the guess register.
REQ-023 cmp_num_1 and cmp_num_2 SHALL be driven directly from the target and guess registers.
REQ-024 COMPARE SHALL sample cmp_match into a result flag and go to RESULT.
REQ-025 RESULT SHALL pulse hit if the flag is set, otherwise miss.
- RESULT SHALL increment score on hit and increment round_no.
- RESULT SHALL then go to DONE if the new round_no equals ROUNDS, otherwise to NEW_ROUND.
REQ-026 Latency SHALL be fixed: guess_valid at cycle N gives hit or miss asserted at cycle N+2.
REQ-027 score SHALL never exceed round_no; both SHALL hold their values in DONE until the next start.
REQ-028 hit and miss SHALL never be asserted together, and SHALL be asserted only in RESULT.

Reset
REQ-029 rst SHALL force IDLE, regardless of the current state, including mid-round.
- Outputs after rst: score=0, round_no=0, hit=0, miss=0, busy=0, game_over=0.
- Registers after rst: target, guess and result flag cleared; LFSR loaded with seed 4'b1001.
REQ-030 rst SHALL take priority over start and guess_valid in the same cycle.

Configuration
REQ-031 When macro SPELE_TIMEOUT_EN is defined, the tick timer SHALL count in WAIT_GUESS.
- On reaching ROUND_TICKS-1 without a guess, the FSM SHALL go to RESULT with the flag cleared, producing a miss.
- If guess_valid and the timeout occur in the same cycle, the guess SHALL win.
REQ-032 When SPELE_TIMEOUT_EN is undefined, no timer SHALL be built and WAIT_GUESS SHALL wait indefinitely.

Verification
REQ-033 rst then start, read cmp_num_1, submit an equal guess -> hit at N+2, score=1, round_no=1.
REQ-034 Submit guess = cmp_num_1 XOR 4'b0001 -> miss at N+2, score unchanged, round_no incremented.
REQ-035 ROUNDS=8, all eight rounds hit -> game_over=1, busy=0, score=8, round_no=8; then start -> score=0, round_no=0, busy=1.
REQ-036 With SPELE_TIMEOUT_EN and ROUND_TICKS=16, no guess -> miss 16..18 cycles after WAIT_GUESS entry; guess_valid in the expiry cycle -> compared normally.
REQ-037 Assert rst in COMPARE -> next cycle IDLE, all outputs at reset values, and the pending hit is never pulsed.
REQ-038 guess_valid and start pulses in COMPARE, RESULT and DONE (start excepted in DONE) -> no state, score or guess register change.
